par_to_ser_tx: RTL and testbench

Parallel-to-serial transmitter: it accepts one byte on a load/ready handshake and shifts it out as a framed asynchronous serial stream. The frame is a start bit, 8 data bits LSB first, an optional parity bit and a stop bit. It is the transmit end of the same line protocol our serial-to-parallel receiver decodes, and it sits between the byte-producing logic and the serial pin.

---
 rtl/serial_pkg.sv | 12 +
 rtl/bit_period_counter.sv | 20 ++
 rtl/par_to_ser_tx.sv | 90 +++++++++
 tb/tb_par_to_ser_tx.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: frame definitions shared by the serial transmitter and receiver.
package serial_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    TRANSMIT = 3'd2,
    STOP     = 3'd3,
    PARITY   = 3'd4
  } state_e;
  localparam int   DATA_W   = 8;
  localparam logic IDLE_LVL = 1'b1;
endpackage

// File: rtl/bit_period_counter.sv
// bit_period_counter: counts 0..CLKS_PER_BIT-1, strobes bit_end on the last count.
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end,
  output logic last_next
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  assign cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;
  // lets the parent register a strobe that lines up with bit_end
  assign last_next = cnt_d == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/par_to_ser_tx.sv
// par_to_ser_tx: byte-in, framed async serial out (start, 8 data LSB first, stop).
// Define PAR_TO_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module par_to_ser_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] par_in,
  input  logic              load,
  output logic              ready,
  output logic              ser_out,
  output logic              done
);
  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ready_q, ready_d, ser_q, ser_d, done_q, done_d;
  logic              bit_end, last_next, clr, take;
`ifdef PAR_TO_SER_PARITY_EN
  logic              par_q, par_d;
`endif
  assign take    = state_q == IDLE && load;
  assign clr     = state_d != state_q || state_q == IDLE;
  assign ready   = ready_q;
  assign ser_out = ser_q;
  assign done    = done_q;
  bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bit_end   (bit_end),
    .last_next (last_next)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (load) state_d = START;
      START:    if (bit_end) state_d = TRANSMIT;
      TRANSMIT:
        if (bit_end && idx_q == 3'd7)
`ifdef PAR_TO_SER_PARITY_EN
          state_d = PARITY;
      PARITY:   if (bit_end) state_d = STOP;
`else
          state_d = STOP;
`endif
      STOP:     if (bit_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // ser_out follows state_q one cycle late, so it never sees load combinationally
  always_comb begin
    idx_d   = state_d == IDLE ? 3'd0 :
              (state_q == TRANSMIT && bit_end && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
    shift_d = take ? par_in : (state_q == TRANSMIT && bit_end) ? shift_q >> 1 : shift_q;
    ready_d = state_d == IDLE;
    done_d  = state_d == STOP && last_next;
`ifdef PAR_TO_SER_PARITY_EN
    par_d   = take ? ^par_in : par_q;
    ser_d   = state_q == START ? 1'b0 : state_q == TRANSMIT ? shift_q[0] :
              state_q == PARITY ? par_q : IDLE_LVL;
`else
    ser_d   = state_q == START ? 1'b0 : state_q == TRANSMIT ? shift_q[0] : IDLE_LVL;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      shift_q <= '0;
      ready_q <= 1'b1;
      ser_q   <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
`ifdef PAR_TO_SER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else par_q <= par_d;
`endif
endmodule

// File: tb/tb_par_to_ser_tx.sv
// tb_par_to_ser_tx: directed frame checks for par_to_ser_tx, with or without PAR_TO_SER_PARITY_EN.
module tb_par_to_ser_tx;
  localparam int C = 4;
`ifdef PAR_TO_SER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk, rst_n, load, ready, ser_out, done;
  logic [7:0] par_in;
  int n_tests = 0, n_fail = 0;
  par_to_ser_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .par_in(par_in), .load(load),
    .ready(ready), .ser_out(ser_out), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one full frame from handshake to stop; par is the hand-computed even parity of b
  task automatic frame(input string nm, input logic [7:0] b, input logic par, input bit hold, input bit poke);
    logic [C-1:0]  s;
    logic [NB-1:0] exp;
    int done_n, done_at;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i+1] = b[i];
    if (NB == 11) exp[9] = par;
    exp[NB-1] = 1'b1;
    s = '0;
    chk({nm, "_rdy_pre"}, ready, 1);
    par_in = b;
    load = 1'b1;
    tick;
    chk({nm, "_rdy_hs"}, ready, 0);
    chk({nm, "_ser_hs"}, ser_out, 1);
    load = hold;
    par_in = 8'h00;
    done_n = 0;
    done_at = -1;
    for (int k = 1; k <= NB * C; k++) begin
      tick;
      if (k == 5) par_in = ~b;
      if (poke && k == 3 * C) begin load = 1'b1; par_in = 8'hFF; end
      if (poke && k == 3 * C + 1) load = 1'b0;
      s[(k-1)%C] = ser_out;
      if (done) begin done_n++; done_at = k; end
      if (k % C == 0) chk($sformatf("%s_bit%0d", nm, (k-1)/C), s, {C{exp[(k-1)/C]}});
      if (k == NB * C - 1) chk({nm, "_rdy_last"}, ready, 0);
    end
    chk({nm, "_done_n"}, done_n, 1);
    chk({nm, "_done_at"}, done_at, NB * C - 1);
    chk({nm, "_rdy_end"}, ready, 1);
  endtask
  task automatic idle_check(input string nm, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick;
      if (ser_out !== 1'b1 || ready !== 1'b1 || done !== 1'b0) ok = 1'b0;
    end
    chk(nm, ok, 1);
  endtask
  initial begin
    int done_n;
    rst_n = 1'b0;
    load = 1'b0;
    par_in = 8'h00;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_ser", ser_out, 1);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_check("idle20", 20);
    frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    frame("x07", 8'h07, 1'b1, 1'b0, 1'b0);
    frame("b2b1", 8'h3C, 1'b0, 1'b1, 1'b0);
    frame("b2b2", 8'hC3, 1'b0, 1'b0, 1'b0);
    frame("ign", 8'h81, 1'b0, 1'b0, 1'b1);
    idle_check("ign_idle", 12);
    par_in = 8'hA5;
    load = 1'b1;
    tick;
    load = 1'b0;
    for (int k = 0; k < 1 + 4 * C + 1; k++) tick;
    chk("mid_ser_busy", ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ser", ser_out, 1);
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    done_n = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done) done_n++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done) done_n++;
    end
    chk("arst_no_done", done_n, 0);
    chk("arst_ready_rel", ready, 1);
    frame("post", 8'h5A, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
